// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and helpers for the input_debounce block.
//   - db_state_t : per-channel debounce FSM state encoding
//   - cnt_width  : width of the stability counter for a given CNT_MAX
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_t;

  // The counter must be able to hold values up to CNT_MAX.
  function automatic int cnt_width(input int cnt_max);
    return $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
//   One debounce channel: SYNC_STAGES-deep synchroniser, stability FSM with
//   counter, and optional registered rise/fall pulse flops.
//   Build option: define DEBOUNCE_EDGE_EN to generate rise_o/fall_o pulses;
//   otherwise the pulse flops are removed and both outputs are tied to 0.
// Ports
//   clk     in  1  rising-edge clock
//   rst_n   in  1  asynchronous active-low reset
//   btn_i   in  1  raw asynchronous input
//   level_o out 1  debounced level
//   rise_o  out 1  one-cycle pulse on level 0->1
//   fall_o  out 1  one-cycle pulse on level 1->0
// -----------------------------------------------------------------------------
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CW   = cnt_width(CNT_MAX);
  localparam logic [CW-1:0]  LAST = CW'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  db_state_t              r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   r_level, w_level_nxt;
  logic                   w_last;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_level_nxt = r_level;
    unique case (r_state)
      STABLE_LO: begin
        if (w_sync) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = CW'(1);
        end
      end
      WAIT_HI: begin
        // Any low sample rejects the candidate edge; count restarts from zero.
        if (!w_sync) begin
          w_state_nxt = STABLE_LO;
        end else if (w_last) begin
          w_state_nxt = STABLE_HI;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!w_sync) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = CW'(1);
        end
      end
      WAIT_LO: begin
        if (w_sync) begin
          w_state_nxt = STABLE_HI;
        end else if (w_last) begin
          w_state_nxt = STABLE_LO;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], btn_i};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  assign level_o = r_level;

`ifdef DEBOUNCE_EDGE_EN
  logic r_rise, r_fall;
  logic w_rise_nxt, w_fall_nxt;

  // Pulses fire on the same edge that flips r_level, so they line up with it.
  assign w_rise_nxt = (r_state == WAIT_HI) && w_sync && w_last;
  assign w_fall_nxt = (r_state == WAIT_LO) && !w_sync && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign rise_o = r_rise;
  assign fall_o = r_fall;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
//   Synchronises and debounces WIDTH raw button/switch inputs. Each channel is
//   an independent debounce_chan instance. level_o[0]/[1] feed the A/B inputs
//   of the downstream gate blocks.
//   Build option: define DEBOUNCE_EDGE_EN to enable rise_o/fall_o pulses;
//   without it both are held at 0 and level_o behaves identically.
// Ports
//   clk     in  1      rising-edge clock
//   rst_n   in  1      asynchronous active-low reset
//   btn_i   in  WIDTH  raw asynchronous inputs, active-high
//   level_o out WIDTH  debounced levels
//   rise_o  out WIDTH  one-cycle pulse per channel on 0->1
//   fall_o  out WIDTH  one-cycle pulse per channel on 1->0
// -----------------------------------------------------------------------------
module input_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_MAX     (CNT_MAX)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_i[i]),
      .level_o (level_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i])
    );
  end

endmodule

// File: tb/tb_input_debounce.sv
module tb_input_debounce;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  localparam int LAT = 18;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn_i;
  logic [1:0] level_o, rise_o, fall_o;

  input_debounce #(.WIDTH(2), .SYNC_STAGES(2), .CNT_MAX(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_i),
    .level_o (level_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o)
  );

  typedef struct {
    int         cyc;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  mon_on = 0;
  bit  done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Expected output event LAT edges after the stimulus edge just issued.
  task automatic push(input logic [1:0] lvl, input logic [1:0] rise,
                      input logic [1:0] fall);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.lvl  = lvl;
    e.rise = EDGE ? rise : 2'b00;
    e.fall = EDGE ? fall : 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic check_outs_zero(input string name);
    checks++;
    if (level_o !== 2'b00 || rise_o !== 2'b00 || fall_o !== 2'b00) begin
      errors++;
      $display("FAIL %s: level=%b rise=%b fall=%b, required all 00", name,
               level_o, rise_o, fall_o);
    end
  endtask

  // Monitor: any level change or pulse is an output event, matched in order.
  initial begin : monitor
    logic [1:0] prev;
    ev_t        e;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (done) break;
      if (mon_on && (level_o !== prev || rise_o !== 2'b00 || fall_o !== 2'b00)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cyc=%0d level=%b rise=%b fall=%b, required no event",
                   cyc, level_o, rise_o, fall_o);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL event_cycle: got cyc=%0d, required cyc=%0d", cyc, e.cyc);
          end
          checks++;
          if (level_o !== e.lvl || rise_o !== e.rise || fall_o !== e.fall) begin
            errors++;
            $display("FAIL event_value: level=%b rise=%b fall=%b, required level=%b rise=%b fall=%b",
                     level_o, rise_o, fall_o, e.lvl, e.rise, e.fall);
          end
        end
      end
      prev = level_o;
    end
  end

  initial begin
    rst_n = 1'b0;
    btn_i = 2'b00;
    repeat (3) @(negedge clk);
    check_outs_zero("reset_state");
    rst_n = 1'b1;
    mon_on = 1'b1;
    repeat (5) @(negedge clk);
    check_outs_zero("idle_after_reset");

    // Clean press on channel 0, then release.
    btn_i = 2'b01; push(2'b01, 2'b01, 2'b00);
    repeat (25) @(negedge clk);
    btn_i = 2'b00; push(2'b00, 2'b00, 2'b01);
    repeat (25) @(negedge clk);

    // Glitch: 10 high samples are too short to be accepted.
    btn_i = 2'b01;
    repeat (10) @(negedge clk);
    btn_i = 2'b00;
    repeat (25) @(negedge clk);
    check_outs_zero("glitch_rejected");

    // Bounce on channel 1: toggle every 3 clk for 30 clk, then steady high.
    for (int s = 0; s < 10; s++) begin
      btn_i[1] = (s % 2 == 0);
      repeat (3) @(negedge clk);
    end
    btn_i[1] = 1'b1; push(2'b10, 2'b10, 2'b00);
    repeat (25) @(negedge clk);

    // Both high, then release both together.
    btn_i = 2'b11; push(2'b11, 2'b01, 2'b00);
    repeat (25) @(negedge clk);
    btn_i = 2'b00; push(2'b00, 2'b00, 2'b11);
    repeat (25) @(negedge clk);

    // Reset in the middle of WAIT_HI with the button held.
    btn_i = 2'b01;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outs_zero("reset_mid_wait");
    repeat (2) @(negedge clk);
    rst_n = 1'b1; push(2'b01, 2'b01, 2'b00);
    repeat (25) @(negedge clk);
    btn_i = 2'b00; push(2'b00, 2'b00, 2'b01);
    repeat (25) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d events never seen, required 0", exp_q.size());
    end
    done = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
